// File: rtl/fpu_pkg.sv
// Shared widths, constants and the stage-1 payload type for the FPU
// normalization shifter.
package fpu_pkg;

    localparam int EXP_W_DEF  = 8;
    localparam int MANT_W_DEF = 28;
    localparam int LZ_W       = 5;

    localparam logic [EXP_W_DEF-1:0] EXP_INF = {EXP_W_DEF{1'b1}};

    // Everything stage 2 needs to finish normalization.
    typedef struct packed {
        logic                  sign;
        logic [EXP_W_DEF-1:0]  exp;
        logic [MANT_W_DEF-1:0] mant;
        logic [LZ_W-1:0]       lz;
        logic                  lz_zero;
    } s1_payload_t;

endpackage

// File: rtl/fpu_lzc_28.sv
// Combinational 28-bit leading-zero counter: four 8-bit leading-one position
// detectors merged pairwise in a two-level tree.
module fpu_lzc_28
    import fpu_pkg::*;
(
    input  logic [27:0]     data,
    output logic [LZ_W-1:0] count,
    output logic            zero
);

    // Returns {found, position of the leading one counted from the MSB}.
    function automatic logic [3:0] lop8(input logic [7:0] v);
        logic [3:0] r;
        casez (v)
            8'b1???????: r = 4'b1000;
            8'b01??????: r = 4'b1001;
            8'b001?????: r = 4'b1010;
            8'b0001????: r = 4'b1011;
            8'b00001???: r = 4'b1100;
            8'b000001??: r = 4'b1101;
            8'b0000001?: r = 4'b1110;
            8'b00000001: r = 4'b1111;
            default:     r = 4'b0000;
        endcase
        return r;
    endfunction

    logic [31:0] padded_s;
    logic [3:0]  g3_s, g2_s, g1_s, g0_s;
    logic [4:0]  hi_s, lo_s;

    // Zero padding at the LSB end leaves the count of any nonzero input unchanged.
    always_comb begin
        padded_s = {data, 4'b0000};
        g3_s = lop8(padded_s[31:24]);
        g2_s = lop8(padded_s[23:16]);
        g1_s = lop8(padded_s[15:8]);
        g0_s = lop8(padded_s[7:0]);
        if (g3_s[3]) begin
            hi_s = {1'b1, 1'b0, g3_s[2:0]};
        end else begin
            hi_s = {g2_s[3], 1'b1, g2_s[2:0]};
        end
        if (g1_s[3]) begin
            lo_s = {1'b1, 1'b0, g1_s[2:0]};
        end else begin
            lo_s = {g0_s[3], 1'b1, g0_s[2:0]};
        end
        if (hi_s[4]) begin
            count = {1'b0, hi_s[3:0]};
            zero  = 1'b0;
        end else begin
            count = {1'b1, lo_s[3:0]};
            zero  = ~lo_s[4];
        end
    end

endmodule

// File: rtl/fpu_norm_shift.sv
// Two-stage normalization shifter for the FPU adder result, valid/ready on both
// sides. Define FPU_NORM_DENORM_EN to produce subnormals instead of flushing.
module fpu_norm_shift
    import fpu_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
)
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_sign,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [MANT_W-1:0] i_mant,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W-2:0] o_mant,
    output logic              o_zero,
    output logic              o_overflow,
    output logic              o_underflow
);

    logic              s1_valid_r, s2_valid_r;
    logic              s2_load_s, s1_adv_s;
    logic [LZ_W-1:0]   lz_s;
    logic              lz_zero_s;
    s1_payload_t       s1_next_s, s1_r;
    logic [EXP_W-1:0]  lz_ext_s;
    logic [EXP_W:0]    exp_inc_s;
    logic [MANT_W-2:0] mant_low_s;
    logic [EXP_W-1:0]  nx_exp_s;
    logic [MANT_W-2:0] nx_mant_s;
    logic              nx_zero_s, nx_ovf_s, nx_unf_s;
`ifdef FPU_NORM_DENORM_EN
    logic [EXP_W-1:0]  den_shift_s;
`endif

    // The carry bit is excluded; the LSB pad keeps the counter 28 bits wide.
    fpu_lzc_28 u_lzc (
        .data  ({i_mant[MANT_W-2:0], 1'b0}),
        .count (lz_s),
        .zero  (lz_zero_s)
    );

    assign s2_load_s = ~s2_valid_r | i_ready;
    assign s1_adv_s  = s1_valid_r & s2_load_s;
    assign o_ready   = ~s1_valid_r | s1_adv_s;
    assign o_valid   = s2_valid_r;

    // Stage-1 payload assembled from the input beat.
    always_comb begin
        s1_next_s.sign    = i_sign;
        s1_next_s.exp     = i_exp;
        s1_next_s.mant    = i_mant;
        s1_next_s.lz      = lz_s;
        s1_next_s.lz_zero = lz_zero_s;
    end

    // Pipeline occupancy; reset drops whatever is in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (o_ready) begin
                s1_valid_r <= i_valid;
            end
            if (s2_load_s) begin
                s2_valid_r <= s1_valid_r;
            end
        end
    end

    // Stage-1 data register, loaded only on an accepted input beat.
    always_ff @(posedge i_clk) begin
        if (o_ready && i_valid) begin
            s1_r <= s1_next_s;
        end
    end

    assign lz_ext_s   = {{(EXP_W-LZ_W){1'b0}}, s1_r.lz};
    assign exp_inc_s  = {1'b0, s1_r.exp} + {{EXP_W{1'b0}}, 1'b1};
    assign mant_low_s = s1_r.mant[MANT_W-2:0];

`ifdef FPU_NORM_DENORM_EN
    // Subnormal shift: one less than the exponent so the result lands at exp 0.
    always_comb begin
        if (s1_r.exp == {EXP_W{1'b0}}) begin
            den_shift_s = {EXP_W{1'b0}};
        end else begin
            den_shift_s = s1_r.exp - {{(EXP_W-1){1'b0}}, 1'b1};
        end
    end
`endif

    // Result classification and shift for stage 2.
    always_comb begin
        nx_exp_s  = {EXP_W{1'b0}};
        nx_mant_s = {(MANT_W-1){1'b0}};
        nx_zero_s = 1'b0;
        nx_ovf_s  = 1'b0;
        nx_unf_s  = 1'b0;
        if (s1_r.mant[MANT_W-1]) begin
            if (exp_inc_s >= {1'b0, EXP_INF}) begin
                nx_ovf_s = 1'b1;
                nx_exp_s = EXP_INF;
            end else begin
                nx_exp_s  = exp_inc_s[EXP_W-1:0];
                nx_mant_s = {s1_r.mant[MANT_W-1:2], s1_r.mant[1] | s1_r.mant[0]};
            end
        end else if (s1_r.lz_zero) begin
            nx_zero_s = 1'b1;
        end else if (lz_ext_s < s1_r.exp) begin
            nx_exp_s  = s1_r.exp - lz_ext_s;
            nx_mant_s = mant_low_s << s1_r.lz;
        end else begin
            nx_unf_s = 1'b1;
`ifdef FPU_NORM_DENORM_EN
            nx_mant_s = mant_low_s << den_shift_s;
`else
            nx_zero_s = 1'b1;
`endif
        end
    end

    // Output registers; they hold while the downstream stalls.
    always_ff @(posedge i_clk) begin
        if (s1_adv_s) begin
            o_sign      <= s1_r.sign;
            o_exp       <= nx_exp_s;
            o_mant      <= nx_mant_s;
            o_zero      <= nx_zero_s;
            o_overflow  <= nx_ovf_s;
            o_underflow <= nx_unf_s;
        end
    end

endmodule

// File: tb/tb_fpu_norm_shift.sv
// Randomized scoreboard bench for fpu_norm_shift; works with or without
// FPU_NORM_DENORM_EN defined.
module tb_fpu_norm_shift;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [26:0] mant;
        logic        zero;
        logic        ovf;
        logic        unf;
    } res_t;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, o_ready, i_sign, o_valid, i_ready;
    logic [7:0]  i_exp, o_exp;
    logic [27:0] i_mant;
    logic [26:0] o_mant;
    logic        o_sign, o_zero, o_overflow, o_underflow;

    res_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cmp = 0;
    int   rdy_mode = 0;
    bit   have_hold = 1'b0;
    res_t held;

    fpu_norm_shift dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_sign(i_sign), .i_exp(i_exp), .i_mant(i_mant), .o_valid(o_valid),
        .i_ready(i_ready), .o_sign(o_sign), .o_exp(o_exp), .o_mant(o_mant),
        .o_zero(o_zero), .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    function automatic res_t model(input logic s, input logic [7:0] e, input logic [27:0] m);
        res_t   r;
        longint x;
        int     lz;
        int     sh;
        r = '0;
        r.sign = s;
        x = longint'(m);
        if (x >= 64'd134217728) begin
            if (int'(e) + 1 == 255) begin
                r.ovf = 1'b1;
                r.exp = 8'd255;
            end else begin
                r.exp = 8'(int'(e) + 1);
                if (x % 2 == 1 && (x / 2) % 2 == 0) r.mant = 27'(x / 2 + 1);
                else r.mant = 27'(x / 2);
            end
        end else if (x == 0) begin
            r.zero = 1'b1;
        end else begin
            lz = 0;
            while (x < 64'd67108864) begin
                x = x * 2;
                lz++;
            end
            if (lz < int'(e)) begin
                r.exp  = 8'(int'(e) - lz);
                r.mant = 27'(x);
            end else begin
                r.unf = 1'b1;
`ifdef FPU_NORM_DENORM_EN
                sh = (e == 8'd0) ? 0 : int'(e) - 1;
                x  = longint'(m);
                repeat (sh) x = x * 2;
                r.mant = 27'(x);
`else
                sh = 0;
                r.zero = 1'b1;
`endif
            end
        end
        return r;
    endfunction

    task automatic fail_line(input string name, input string act, input string req);
        n_err++;
        $display("FAIL %s: got %s, expected %s", name, act, req);
    endtask

    // Present one beat until accepted, then push its expected result.
    task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m, input res_t expv);
        bit acc;
        int guard;
        i_valid = 1'b1; i_sign = s; i_exp = e; i_mant = m;
        acc = 1'b0; guard = 0;
        while (!acc && guard < 200) begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
            guard++;
        end
        i_valid = 1'b0;
        n_cmp++;
        if (!acc) begin
            fail_line("send_timeout", "no accept", "accept within 200 cycles");
        end else begin
            sb.push_back(expv);
            n_vec++;
        end
    endtask

    task automatic send_rand(input logic s, input logic [7:0] e, input logic [27:0] m);
        send(s, e, m, model(s, e, m));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(posedge i_clk);
            guard++;
        end
        n_cmp++;
        if (sb.size() != 0) fail_line("drain", $sformatf("%0d left", sb.size()), "0 left");
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) fail_line(name, $sformatf("%b", act), $sformatf("%b", req));
    endtask

    // Downstream ready generator.
    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            case (rdy_mode)
                0:       i_ready = 1'b1;
                1:       i_ready = 1'b0;
                default: i_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: pop and compare on transfers, check stability while stalled.
    always @(negedge i_clk) begin
        res_t got;
        res_t expv;
        got = {o_sign, o_exp, o_mant, o_zero, o_overflow, o_underflow};
        if (i_rst) begin
            have_hold = 1'b0;
        end else begin
            if (have_hold) begin
                n_cmp++;
                if (o_valid !== 1'b1 || got !== held)
                    fail_line("stall_hold", $sformatf("v=%b %h", o_valid, got), $sformatf("v=1 %h", held));
            end
            if (o_valid === 1'b1 && i_ready === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    fail_line("unexpected_output", $sformatf("%h", got), "no beat");
                end else begin
                    expv = sb.pop_front();
                    if (got !== expv)
                        fail_line("beat", $sformatf("s=%b e=%h m=%h z=%b o=%b u=%b", got.sign, got.exp, got.mant, got.zero, got.ovf, got.unf),
                                  $sformatf("s=%b e=%h m=%h z=%b o=%b u=%b", expv.sign, expv.exp, expv.mant, expv.zero, expv.ovf, expv.unf));
                end
            end
            have_hold = (o_valid === 1'b1 && i_ready === 1'b0);
            held = got;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] m;
        logic [7:0]  e;
        res_t        d;
        i_rst = 1'b1; i_valid = 1'b0; i_sign = 1'b0; i_exp = 8'h00; i_mant = 28'h0;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check_bit("reset_o_valid", o_valid, 1'b0);
        check_bit("reset_o_ready", o_ready, 1'b1);
        @(posedge i_clk); #1;

        // Directed vectors with hand-derived results.
        send(1'b0, 8'h80, 28'h4000000, '{1'b0, 8'h80, 27'h4000000, 1'b0, 1'b0, 1'b0});
        send(1'b1, 8'h80, 28'h8000001, '{1'b1, 8'h81, 27'h4000001, 1'b0, 1'b0, 1'b0});
        send(1'b0, 8'hFE, 28'h8000000, '{1'b0, 8'hFF, 27'h0000000, 1'b0, 1'b1, 1'b0});
        send(1'b0, 8'h80, 28'h0000100, '{1'b0, 8'h6E, 27'h4000000, 1'b0, 1'b0, 1'b0});
        send(1'b1, 8'h80, 28'h0000000, '{1'b1, 8'h00, 27'h0000000, 1'b1, 1'b0, 1'b0});
`ifdef FPU_NORM_DENORM_EN
        d = '{1'b0, 8'h00, 27'h0000400, 1'b0, 1'b0, 1'b1};
`else
        d = '{1'b0, 8'h00, 27'h0000000, 1'b1, 1'b0, 1'b1};
`endif
        send(1'b0, 8'h03, 28'h0000100, d);
        drain();

        // Random beats with random input bubbles and downstream stalls.
        rdy_mode = 2;
        for (int k = 0; k < 1000; k++) begin
            case ($urandom_range(0, 7))
                0:       m = 28'h0;
                1:       m = {1'b1, 27'($urandom)};
                default: m = {1'b0, 27'($urandom)} >> $urandom_range(0, 27);
            endcase
            case ($urandom_range(0, 3))
                0:       e = 8'($urandom_range(0, 30));
                1:       e = 8'd254;
                default: e = 8'($urandom_range(0, 254));
            endcase
            send_rand(1'($urandom), e, m);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge i_clk); #1;
            end
        end
        rdy_mode = 0;
        drain();

        // Reset with two beats in flight, then latency of the next beat.
        rdy_mode = 1;
        repeat (2) @(posedge i_clk);
        #1;
        send(1'b0, 8'h80, 28'h4000000, '0);
        send(1'b1, 8'h81, 28'h4000000, '0);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        sb.delete();
        rdy_mode = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check_bit("post_reset_o_valid", o_valid, 1'b0);
        end
        check_bit("post_reset_o_ready", o_ready, 1'b1);
        @(posedge i_clk); #1;
        send_rand(1'b0, 8'h40, 28'h1234567);
        @(negedge i_clk);
        check_bit("latency_1cyc_empty", o_valid, 1'b0);
        @(negedge i_clk);
        check_bit("latency_2cyc_valid", o_valid, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_norm_shift.md
FPU_NORM_SHIFT -- requirements
Module: fpu_norm_shift

Interface
REQ-001 Parameter MANT_W, default 28, SHALL set the input mantissa width: bit MANT_W-1 is the carry, MANT_W-2 the hidden bit, [2:0] guard/round/sticky.
REQ-002 Parameter EXP_W, default 8, SHALL set the biased exponent width; all-ones is reserved for inf.
REQ-003 i_clk  in  1  rising-edge clock; the design has one clock.
REQ-004 i_rst  in  1  reset, synchronous and active-high.
REQ-005 i_valid  in  1  input beat valid.
REQ-006 o_ready  out  1  block accepts input this cycle.
REQ-007 i_sign  in  1  sign of unnormalized adder result.
REQ-008 i_exp  in  EXP_W  biased exponent before normalization.
REQ-009 i_mant  in  MANT_W  unnormalized mantissa sum.
REQ-010 o_valid  out  1  output beat valid.
REQ-011 i_ready  in  1  downstream (rounder) accepts output.
REQ-012 o_sign  out  1  sign, passed through unchanged.
REQ-013 o_exp  out  EXP_W  normalized exponent.
REQ-014 o_mant  out  MANT_W-1  normalized mantissa; hidden bit at MSB.
REQ-015 o_zero, o_overflow, o_underflow  out  1 each  result class flags.

Function
REQ-016 Two-stage pipeline: stage 1 registers the leading-zero count (lz, counted from bit MANT_W-2) plus inputs; stage 2 registers shifted mantissa, exponent and flags; latency is exactly 2 cycles with no stalls.
REQ-017 A beat transfers on a port only when its valid and ready are both high in the same cycle.
REQ-018 Each stage SHALL load when it is empty or its contents leave in that cycle; o_ready = ~s1_valid | s1_advance, with no combinational path from i_valid to o_ready.
REQ-019 Carry case (i_mant[MANT_W-1]=1): shift right 1, OR the shifted-out bit into o_mant[0] (sticky), exp+1.
REQ-020 If the carry case makes exp+1 = 2^EXP_W-1: o_overflow=1, o_exp=all-ones, o_mant=0.
REQ-021 i_mant=0: o_zero=1, o_exp=0, o_mant=0, other flags 0.
REQ-022 Normal case, lz < i_exp: shift left by lz, o_exp = i_exp-lz, zero-fill the LSBs.
REQ-023 Underflow case, lz >= i_exp with i_mant nonzero and no carry: o_underflow=1; the result follows REQ-031/REQ-032.
REQ-024 Stalled output (o_valid=1, i_ready=0) SHALL hold every output stable until it is accepted.
REQ-025 Simultaneous accept-in and accept-out at full occupancy SHALL sustain 1 beat/cycle without bubbles.

Reset
REQ-026 While i_rst=1 at a clock edge, both stage valids SHALL clear; o_valid=0, o_ready=1 in the following cycle.
REQ-027 Data registers are not reset; o_sign/o_exp/o_mant/flags are don't-care while o_valid=0.
REQ-028 Reset asserted mid-operation SHALL discard in-flight beats with no output for them.

Configuration
REQ-029 Macro FPU_NORM_DENORM_EN SHALL select the underflow handling.
REQ-030 Both variants SHALL keep the same ports and the same latency.
REQ-031 Without FPU_NORM_DENORM_EN: underflow flushes to zero, giving o_zero=1, o_exp=0, o_mant=0.
REQ-032 With FPU_NORM_DENORM_EN: underflow shifts left by (i_exp==0 ? 0 : i_exp-1) and sets o_exp=0, giving a subnormal; o_zero=0.

Structure
REQ-033 Shared package fpu_pkg SHALL hold EXP_W/MANT_W defaults, the EXP_INF constant and a packed struct for the stage-1 payload.
REQ-034 One sub-module, fpu_lzc_28, SHALL be a combinational leading-zero counter built as a tree of 8-bit leading-one-position detectors, with a zero flag.

Verification
REQ-035 i_exp=0x80, i_mant=0x4000000 (hidden set) -> 2 cycles later o_exp=0x80, o_mant=0x4000000, all flags 0.
REQ-036 i_exp=0x80, i_mant=0x8000001 -> o_exp=0x81, o_mant=0x4000001 (sticky kept); i_exp=0xFE with carry -> o_overflow=1, o_exp=0xFF, o_mant=0.
REQ-037 i_exp=0x80, i_mant=0x0000100 (lz=18) -> o_exp=0x6E, o_mant=0x4000000; i_mant=0 -> o_zero=1.
REQ-038 i_exp=3, i_mant=0x0000100 -> o_underflow=1; macro off: o_zero=1; macro on: o_exp=0, o_mant=0x0000400.
REQ-039 Random i_valid/i_ready toggling for 1000 beats -> output order and values match the reference model, no drop or duplication, outputs stable while stalled.
REQ-040 i_rst pulsed with 2 beats in flight -> no o_valid for them; the next input emerges after exactly 2 cycles.
